branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow recovery for the 5-stage pipelined core.
- Keeps an in-order queue of per-instruction predicted next-PCs pushed at IF, and pops one entry per instruction resolving in EX.
- Compares each popped prediction with the actual next PC. On mismatch it issues a registered redirect and flushes the wrong-path front-end stages for a fixed number of cycles.
- Sits between the PC selector / branch predictor (IF) and the EX branch unit; drives the PC mux select and the IF/ID and ID/EX flush lines.

Parameters:
- XLEN, 32, address width.
- QDEPTH, 4, in-flight prediction entries; power of two, ≥2.
- FLUSH_CYCLES, 2, cycles flush_o stays high per mispredict; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- stall_i  in  1  IF/ID hold (stop_IF_ID); blocks push.
- if_fire_i  in  1  instruction leaves IF this cycle.
- if_pred_npc_i  in  XLEN  predicted next PC for that instruction.
- ex_valid_i  in  1  instruction resolves in EX this cycle.
- ex_is_ctrl_i  in  1  resolving instruction is branch/jump; used by counters only.
- ex_next_pc_i  in  XLEN  actual next PC of resolving instruction.
- redirect_o  out  1  one-cycle pulse: PC mux takes redirect_pc_o.
- redirect_pc_o  out  XLEN  corrected fetch PC.
- flush_o  out  1  clear IF/ID and ID/EX valid bits.
- q_full_o  out  1  queue full; front end must stall.
- underflow_o  out  1  sticky: pop attempted on empty queue.

Behaviour:
- Reset (rst_n=0 at a clk edge): state RUN; queue empty (rd_ptr=wr_ptr=0, count=0); redirect_o=0, redirect_pc_o=0, flush_o=0, underflow_o=0, q_full_o=0. Reset mid-FLUSH aborts the flush and takes the same values.
- Push: if_fire_i & ~stall_i & state==RUN & ~mispredict_now. Writes if_pred_npc_i at wr_ptr; wr_ptr wraps modulo QDEPTH.
- Pop: ex_valid_i & state==RUN & count!=0. Compare mem[rd_ptr] with ex_next_pc_i; rd_ptr wraps.
- mispredict_now = pop & (mem[rd_ptr] != ex_next_pc_i), full XLEN compare.
- Push with pop in the same cycle: count unchanged. This is legal when full; the freed slot is reused in that cycle.
- Push while full without pop: dropped; q_full_o already requested a stall. Bench treats this as a protocol error.
- ex_valid_i with count==0: no pop, no mispredict, underflow_o set to 1 until reset.
- q_full_o = (count==QDEPTH), combinational from registered count.
- FSM, two states:
  - RUN: on mispredict_now, next state FLUSH. Register redirect_pc_o<=ex_next_pc_i and fcnt<=FLUSH_CYCLES-1, then clear the queue (pointers and count to 0). A simultaneous push is discarded.
  - FLUSH: flush_o=1. Pushes and pops are ignored, and ex_valid_i does not set underflow. When fcnt==0, next state RUN; otherwise fcnt decrements.
- redirect_o=1 only in the first FLUSH cycle, i.e. exactly 1 cycle after the mispredicting ex_valid_i edge.
- Latency: mispredict at edge N gives redirect_o/flush_o high in cycle N+1, and flush_o low from cycle N+1+FLUSH_CYCLES.
- redirect_pc_o holds its value until the next mispredict.
- All outputs are registered or decoded from registers only; no input-to-output combinational path.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_EN.
- Defined:
  - Adds outputs perf_ctrl_cnt_o[31:0] (pops with ex_is_ctrl_i=1) and perf_mispred_cnt_o[31:0] (mispredict_now events).
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (core_pkg / define.v): XLEN, state encodings ST_RUN/ST_FLUSH, RESET_PC constant.
- One natural sub-module: pred_npc_fifo. It is a synchronous circular buffer with push/pop/clear, count, full/empty and read-data-at-head.
- The FSM, compare and flush counter stay in the top.

Test Plan:
- Correct prediction: push 0x104, then ex_valid_i with ex_next_pc_i=0x104. Required: no redirect, flush_o=0, count back to 0.
- Mispredict: queue holds 0x108, 0x10C; EX resolves with next PC 0x200. Required:
  - redirect_o=1 for exactly one cycle with redirect_pc_o=0x200.
  - flush_o high for 2 cycles; queue empty afterwards.
  - A push in the mispredict cycle is dropped.
- Full/wrap: push 4 entries, q_full_o=1. Then simultaneous push+pop 6 times with matching PCs. Required: count stays 4, pointers wrap, no false mispredict.
- Underflow: ex_valid_i with empty queue. Required: underflow_o=1 and stays 1; no redirect.
- Reset mid-flush: assert rst_n=0 in the 2nd FLUSH cycle. Required: next cycle flush_o=0, redirect_o=0, count=0, state RUN.
- Stall: stall_i=1 with if_fire_i=1 for 3 cycles. Required: count unchanged. With BRANCH_REDIRECT_PERF_EN, after 3 ctrl pops (1 mispredicted): perf_ctrl_cnt_o=3, perf_mispred_cnt_o=1.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: address width,
// FSM state encoding and the fetch PC value used at reset.
package branch_redirect_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_redirect_ctrl_pred_npc_fifo.sv
// Circular buffer of predicted next-PCs: push at tail, pop at head, clear,
// occupancy count and combinational head read.
module branch_redirect_ctrl_pred_npc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [W-1:0]                   wdata_i,
    output logic [W-1:0]                   rdata_o,
    output logic [$clog2(DEPTH):0]         count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (count_q == (AW+1)'(DEPTH));
    assign empty_s   = (count_q == {(AW+1){1'b0}});
    // A full queue still accepts a push when the head is freed in the same cycle.
    assign do_push_s = push_i & (~full_s | pop_i) & ~clr_i;
    assign do_pop_s  = pop_i & ~empty_s & ~clr_i;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next occupancy from push/pop activity.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else if (clr_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            count_q <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: checks EX-resolved next-PCs against queued IF
// predictions and drives redirect/flush. Optional perf counters: BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            if_fire_i,
    input  logic [XLEN-1:0] if_pred_npc_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_ctrl_i,
    input  logic [XLEN-1:0] ex_next_pc_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            q_full_o,
    output logic            underflow_o
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]     perf_ctrl_cnt_o,
    output logic [31:0]     perf_mispred_cnt_o
`endif
);
    localparam int unsigned CW = $clog2(QDEPTH);
    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e          state_q;
    logic [FW-1:0]   fcnt_q;
    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            underflow_q;

    logic [XLEN-1:0] head_s;
    logic [CW:0]     count_s;
    logic            run_s;
    logic            empty_s;
    logic            pop_s;
    logic            mispredict_s;
    logic            push_s;

    assign run_s        = (state_q == ST_RUN);
    assign empty_s      = (count_s == {(CW+1){1'b0}});
    assign pop_s        = ex_valid_i & run_s & ~empty_s;
    assign mispredict_s = pop_s & (head_s != ex_next_pc_i);
    assign push_s       = if_fire_i & ~stall_i & run_s & ~mispredict_s;

    branch_redirect_ctrl_pred_npc_fifo #(
        .DEPTH (QDEPTH),
        .W     (XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (mispredict_s),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (if_pred_npc_i),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    // Recovery FSM with registered redirect pulse, redirect PC and sticky underflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            fcnt_q        <= {FW{1'b0}};
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
            underflow_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_valid_i && empty_s) begin
                        underflow_q <= 1'b1;
                    end
                    if (mispredict_s) begin
                        state_q       <= ST_FLUSH;
                        fcnt_q        <= FW'(FLUSH_CYCLES - 1);
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= ex_next_pc_i;
                    end else begin
                        redirect_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    redirect_q <= 1'b0;
                    if (fcnt_q == {FW{1'b0}}) begin
                        state_q <= ST_RUN;
                    end else begin
                        fcnt_q <= fcnt_q - {{(FW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = (state_q == ST_FLUSH);
    assign q_full_o      = (count_s == (CW+1)'(QDEPTH));
    assign underflow_o   = underflow_q;

`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0] perf_ctrl_q;
    logic [31:0] perf_mispred_q;

    // Event counters; wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ctrl_q    <= 32'd0;
            perf_mispred_q <= 32'd0;
        end else begin
            if (pop_s && ex_is_ctrl_i) begin
                perf_ctrl_q <= perf_ctrl_q + 32'd1;
            end
            if (mispredict_s) begin
                perf_mispred_q <= perf_mispred_q + 32'd1;
            end
        end
    end

    assign perf_ctrl_cnt_o    = perf_ctrl_q;
    assign perf_mispred_cnt_o = perf_mispred_q;
`else
    logic unused_ctrl_s;
    assign unused_ctrl_s = ex_is_ctrl_i;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: expected redirect PCs are queued
// by the stimulus and matched by a monitor whenever redirect_o pulses.
module tb_branch_redirect_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall_i;
    logic            if_fire_i;
    logic [XLEN-1:0] if_pred_npc_i;
    logic            ex_valid_i;
    logic            ex_is_ctrl_i;
    logic [XLEN-1:0] ex_next_pc_i;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_o;
    logic            q_full_o;
    logic            underflow_o;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0]     perf_ctrl_cnt_o;
    logic [31:0]     perf_mispred_cnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [XLEN-1:0] sb_q[$];
    logic            prev_redirect = 1'b0;
    bit              done = 1'b0;

    branch_redirect_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall_i            (stall_i),
        .if_fire_i          (if_fire_i),
        .if_pred_npc_i      (if_pred_npc_i),
        .ex_valid_i         (ex_valid_i),
        .ex_is_ctrl_i       (ex_is_ctrl_i),
        .ex_next_pc_i       (ex_next_pc_i),
        .redirect_o         (redirect_o),
        .redirect_pc_o      (redirect_pc_o),
        .flush_o            (flush_o),
        .q_full_o           (q_full_o),
        .underflow_o        (underflow_o)
`ifdef BRANCH_REDIRECT_PERF_EN
        ,
        .perf_ctrl_cnt_o    (perf_ctrl_cnt_o),
        .perf_mispred_cnt_o (perf_mispred_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected redirect PC.
    always @(negedge clk) begin
        if (!done && rst_n) begin
            if (redirect_o) begin
                if (prev_redirect) begin
                    chk("redirect_pulse_width", 32'd2, 32'd1);
                end else if (sb_q.size() == 0) begin
                    chk("unexpected_redirect", redirect_pc_o, 32'hFFFF_FFFF);
                end else begin
                    chk("redirect_pc", redirect_pc_o, sb_q.pop_front());
                end
            end
        end
        prev_redirect = redirect_o;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i       = 1'b0;
        if_fire_i     = 1'b0;
        if_pred_npc_i = 32'h0;
        ex_valid_i    = 1'b0;
        ex_is_ctrl_i  = 1'b0;
        ex_next_pc_i  = 32'h0;
    endtask

    task automatic push(input logic [31:0] pc);
        idle();
        if_fire_i     = 1'b1;
        if_pred_npc_i = pc;
        cyc();
        idle();
    endtask

    task automatic pop(input logic [31:0] npc, input logic ctrl);
        idle();
        ex_valid_i   = 1'b1;
        ex_is_ctrl_i = ctrl;
        ex_next_pc_i = npc;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_redirect", 32'(redirect_o), 32'd0);
        chk("rst_redirect_pc", redirect_pc_o, 32'h0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_full", 32'(q_full_o), 32'd0);
        chk("rst_underflow", 32'(underflow_o), 32'd0);
        chk("rst_count", 32'(dut.count_s), 32'd0);

        // Correct prediction.
        push(32'h104);
        chk("t1_count_push", 32'(dut.count_s), 32'd1);
        pop(32'h104, 1'b1);
        chk("t1_redirect", 32'(redirect_o), 32'd0);
        chk("t1_flush", 32'(flush_o), 32'd0);
        chk("t1_count", 32'(dut.count_s), 32'd0);

        // Mispredict with a same-cycle push that must be dropped.
        push(32'h108);
        push(32'h10C);
        sb_q.push_back(32'h200);
        ex_valid_i    = 1'b1;
        ex_next_pc_i  = 32'h200;
        if_fire_i     = 1'b1;
        if_pred_npc_i = 32'h300;
        cyc();
        idle();
        if_fire_i     = 1'b1;
        if_pred_npc_i = 32'h400;
        ex_valid_i    = 1'b1;
        ex_next_pc_i  = 32'h404;
        chk("t2_redirect", 32'(redirect_o), 32'd1);
        chk("t2_redirect_pc", redirect_pc_o, 32'h200);
        chk("t2_flush_c1", 32'(flush_o), 32'd1);
        chk("t2_count_c1", 32'(dut.count_s), 32'd0);
        cyc();
        idle();
        chk("t2_redirect_c2", 32'(redirect_o), 32'd0);
        chk("t2_flush_c2", 32'(flush_o), 32'd1);
        chk("t2_count_c2", 32'(dut.count_s), 32'd0);
        cyc();
        chk("t2_flush_done", 32'(flush_o), 32'd0);
        chk("t2_count_done", 32'(dut.count_s), 32'd0);
        chk("t2_no_underflow", 32'(underflow_o), 32'd0);
        chk("t2_pc_hold", redirect_pc_o, 32'h200);

        // Fill, then six simultaneous push+pop cycles across the wrap.
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i));
        chk("t3_full", 32'(q_full_o), 32'd1);
        chk("t3_count_full", 32'(dut.count_s), 32'd4);
        for (int i = 0; i < 6; i++) begin
            if_fire_i     = 1'b1;
            if_pred_npc_i = 32'h510 + 32'(4 * i);
            ex_valid_i    = 1'b1;
            ex_next_pc_i  = 32'h500 + 32'(4 * i);
            cyc();
            idle();
            chk("t3_count_pp", 32'(dut.count_s), 32'd4);
            chk("t3_full_pp", 32'(q_full_o), 32'd1);
            chk("t3_no_redirect", 32'(redirect_o), 32'd0);
        end
        for (int i = 0; i < 4; i++) pop(32'h518 + 32'(4 * i), 1'b0);
        chk("t3_drained", 32'(dut.count_s), 32'd0);
        chk("t3_not_full", 32'(q_full_o), 32'd0);
        chk("t3_flush", 32'(flush_o), 32'd0);

        // Stall blocks pushes.
        push(32'h600);
        for (int i = 0; i < 3; i++) begin
            stall_i       = 1'b1;
            if_fire_i     = 1'b1;
            if_pred_npc_i = 32'h700;
            cyc();
            chk("t4_stall_count", 32'(dut.count_s), 32'd1);
        end
        idle();
        pop(32'h600, 1'b0);
        chk("t4_count", 32'(dut.count_s), 32'd0);
        chk("t4_no_redirect", 32'(redirect_o), 32'd0);

        // Underflow is sticky.
        pop(32'h123, 1'b0);
        chk("t5_underflow", 32'(underflow_o), 32'd1);
        chk("t5_no_redirect", 32'(redirect_o), 32'd0);
        chk("t5_no_flush", 32'(flush_o), 32'd0);
        cyc();
        cyc();
        chk("t5_underflow_sticky", 32'(underflow_o), 32'd1);

        // Reset during the second flush cycle.
        push(32'h800);
        sb_q.push_back(32'h900);
        pop(32'h900, 1'b1);
        chk("t6_flush_c1", 32'(flush_o), 32'd1);
        cyc();
        chk("t6_flush_c2", 32'(flush_o), 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("t6_flush", 32'(flush_o), 32'd0);
        chk("t6_redirect", 32'(redirect_o), 32'd0);
        chk("t6_count", 32'(dut.count_s), 32'd0);
        chk("t6_state", 32'(dut.state_q), 32'd0);
        chk("t6_underflow", 32'(underflow_o), 32'd0);
        chk("t6_redirect_pc", redirect_pc_o, 32'h0);

        // Three control pops, one mispredicted.
        push(32'hA00);
        push(32'hA04);
        pop(32'hA00, 1'b1);
        pop(32'hA04, 1'b1);
        push(32'hA08);
        sb_q.push_back(32'hB00);
        pop(32'hB00, 1'b1);
        chk("t7_redirect", 32'(redirect_o), 32'd1);
        cyc();
        cyc();
        chk("t7_flush_done", 32'(flush_o), 32'd0);
`ifdef BRANCH_REDIRECT_PERF_EN
        chk("t7_perf_ctrl", perf_ctrl_cnt_o, 32'd3);
        chk("t7_perf_mispred", perf_mispred_cnt_o, 32'd1);
`endif
        cyc();
        done = 1'b1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
